// File: rtl/pipeline_stage_4.sv
// MEM stage: issues data-memory accesses, stalls until ack or timeout, and loads the MEM/WB registers.
// Latency: 0 stall cycles on same-cycle ack. Backpressure: Stall = dmem_req & ~dmem_ack holds upstream.
module pipeline_stage_4 #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Flush,
  input  logic [15:0] EXMEM_M,
  input  logic [3:0]  EXMEM_WB,
  input  logic [31:0] EXMEM_ALU,
  input  logic [31:0] EXMEM_MData,
  input  logic [4:0]  EXMEM_Waddr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        Stall,
  output logic        MEMWB_WB,
  output logic [4:0]  MEMWB_Waddr,
  output logic [31:0] WB_Data,
  output logic [31:0] M_Data,
  output logic        mem_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending, is_store, is_load, timeout;
  logic          wb_q;
  logic [4:0]    waddr_q;
  logic [31:0]   wb_data_q, m_data_q;
  logic          err_q;
  logic          unused_ctrl;

  assign unused_ctrl = ^{EXMEM_M[15:2], EXMEM_WB[3:2]};

  assign pending  = EXMEM_M[0] | EXMEM_M[1];
  assign is_store = EXMEM_M[1];
  assign is_load  = EXMEM_M[0] & ~EXMEM_M[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timeout  = 1'b0;
    dmem_req = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req = pending;
        if (pending && !dmem_ack) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = IDLE;
        // The IDLE issue cycle already stalled once, so TIMEOUT stall cycles end one count early.
        end else if (cnt_q == CW'(TIMEOUT - 2)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = EXMEM_ALU;
  assign dmem_wdata = EXMEM_MData;
  assign Stall      = dmem_req & ~dmem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wb_q      <= 1'b0;
      waddr_q   <= '0;
      wb_data_q <= '0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timeout) begin
        wb_q      <= 1'b0;
        waddr_q   <= '0;
        wb_data_q <= '0;
        err_q     <= 1'b1;
      end else if (!Stall) begin
        // An access that already waited must retire even if Flush is raised.
        if (Flush && state_q == IDLE) begin
          wb_q      <= 1'b0;
          waddr_q   <= '0;
          wb_data_q <= '0;
        end else begin
          wb_q      <= EXMEM_WB[0] & ~is_store;
          waddr_q   <= EXMEM_Waddr;
          wb_data_q <= (EXMEM_WB[1] && is_load) ? dmem_rdata : EXMEM_ALU;
        end
      end
      if (is_load && dmem_req && dmem_ack) begin
        m_data_q <= dmem_rdata;
      end
    end
  end

  assign MEMWB_WB    = wb_q;
  assign MEMWB_Waddr = waddr_q;
  assign WB_Data     = wb_data_q;
  assign M_Data      = m_data_q;
  assign mem_err     = err_q;
endmodule
